// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
// Contents: FSM state encoding, default reset PC / memory depth, the NOP
// encoding driven on an empty slot, and the fetch-address legality check.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0004;
  localparam int unsigned DEPTH_WORDS_DEF = 1024;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

  // A fetch address is legal when word aligned and inside the memory.
  // limit is the first byte address past the end of memory.
  function automatic logic pc_legal(input logic [31:0] addr, input logic [31:0] limit);
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, fetches from a combinational-read instruction
// memory into the IF/ID slot (valid/ready toward decode), takes branch
// redirects from EX and parks in FAULT on an illegal fetch address.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   imem_addr/imem_instr  byte address out (= pc register), word back same cycle
//   if_pc/if_instr/if_valid, id_ready   IF/ID slot and decode handshake
//   br_taken/br_target    one-cycle redirect request from EX
//   fault, fetch_cnt, redirect_cnt      status and event counters
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fault,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt
);

  localparam logic [31:0] PC_LIMIT = 32'(DEPTH_WORDS * 4);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  if_instr_q;
  logic         if_valid_q;
  logic         fault_q;
  logic [31:0]  fetch_cnt_q;
  logic [31:0]  redirect_cnt_q;

  logic slot_free;
  logic target_ok;
  logic pc_ok;

  // The slot can take a new word when empty or when decode drains it now.
  assign slot_free = !if_valid_q || id_ready;
  assign target_ok = pc_legal(br_target, PC_LIMIT);
  assign pc_ok     = pc_legal(pc_q, PC_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_PC;
      if_pc_q        <= '0;
      if_instr_q     <= NOP_INSTR;
      if_valid_q     <= 1'b0;
      fault_q        <= 1'b0;
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      case (state_q)
        // One dead cycle after reset; redirects are deliberately dropped here.
        ST_BOOT: begin
          state_q <= ST_RUN;
        end

        ST_RUN: begin
          if (br_taken && target_ok) begin
            // Flush the wrong-path slot even if decode is stalled.
            pc_q           <= br_target;
            if_valid_q     <= 1'b0;
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
          end else if (br_taken) begin
            state_q    <= ST_FAULT;
            fault_q    <= 1'b1;
            if_valid_q <= 1'b0;
          end else if (!pc_ok && slot_free) begin
            // Ran off the end of memory: never load the out-of-range word.
            state_q    <= ST_FAULT;
            fault_q    <= 1'b1;
            if_valid_q <= 1'b0;
          end else if (slot_free) begin
            if_pc_q     <= pc_q;
            if_instr_q  <= imem_instr;
            if_valid_q  <= 1'b1;
            pc_q        <= pc_q + 32'd4;
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
          end
        end

        ST_FAULT: begin
          if_valid_q <= 1'b0;
          if (br_taken && target_ok) begin
            // Resume: the target is fetched on the following edge.
            pc_q           <= br_target;
            state_q        <= ST_RUN;
            fault_q        <= 1'b0;
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
          end
        end

        default: begin
          state_q    <= ST_FAULT;
          fault_q    <= 1'b1;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign if_pc        = if_pc_q;
  assign if_valid     = if_valid_q;
  // Empty slot always shows NOP regardless of the stale stored word.
  assign if_instr     = if_valid_q ? if_instr_q : NOP_INSTR;
  assign fault        = fault_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        id_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fault;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  int errors;
  int checks;

  fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .id_ready    (id_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .fault       (fault),
    .fetch_cnt   (fetch_cnt),
    .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word k holds 0x1000_0000 + k; beyond the end returns a marker.
  assign imem_instr = (imem_addr < 32'h1000) ? (32'h1000_0000 + (imem_addr >> 2))
                                             : 32'hBAD0_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] ins);
    chk({tag, ".valid"}, {31'd0, v}, {31'd0, if_valid});
    chk({tag, ".pc"}, if_pc, pc);
    chk({tag, ".instr"}, if_instr, ins);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    id_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    step();
    step();

    // Reset state
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.pc", if_pc, 32'h0);
    chk("rst.instr", if_instr, NOP);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.addr", imem_addr, 32'h4);
    chk("rst.fcnt", fetch_cnt, 32'd0);
    chk("rst.rcnt", redirect_cnt, 32'd0);

    // Release; BOOT edge fetches nothing
    rst_n    = 1'b1;
    id_ready = 1'b1;
    step();
    chk("boot.valid", {31'd0, if_valid}, 32'd0);
    chk("boot.addr", imem_addr, 32'h4);

    // Straight-line fetch, one per cycle
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_slot($sformatf("line%0d", k), 1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k));
    end
    chk("line.fcnt", fetch_cnt, 32'd6);
    chk("line.addr", imem_addr, 32'd28);

    // Redirect to 0xC, then stall with pc 12 in the slot
    br_taken  = 1'b1;
    br_target = 32'hC;
    step();
    br_taken = 1'b0;
    chk("rd0.valid", {31'd0, if_valid}, 32'd0);
    chk("rd0.addr", imem_addr, 32'hC);
    chk("rd0.rcnt", redirect_cnt, 32'd1);
    step();
    chk_slot("rd0.tgt", 1'b1, 32'hC, 32'h1000_0003);
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_slot("stall", 1'b1, 32'hC, 32'h1000_0003);
      chk("stall.addr", imem_addr, 32'h10);
      chk("stall.fcnt", fetch_cnt, 32'd7);
    end
    id_ready = 1'b1;
    step();
    chk_slot("unstall1", 1'b1, 32'h10, 32'h1000_0004);
    chk("unstall1.fcnt", fetch_cnt, 32'd8);
    step();
    chk_slot("unstall2", 1'b1, 32'h14, 32'h1000_0005);
    chk("unstall2.addr", imem_addr, 32'h18);

    // Redirect while decode stalls: redirect wins, one bubble
    id_ready  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h74;
    step();
    br_taken = 1'b0;
    chk_slot("rdst.flush", 1'b0, 32'h14, NOP);
    chk("rdst.addr", imem_addr, 32'h74);
    chk("rdst.rcnt", redirect_cnt, 32'd2);
    step();
    chk_slot("rdst.tgt", 1'b1, 32'h74, 32'h1000_001D);
    chk("rdst.fcnt", fetch_cnt, 32'd10);
    id_ready = 1'b1;

    // Illegal (misaligned, out of range) redirect -> FAULT, pc unchanged
    br_taken  = 1'b1;
    br_target = 32'h4002;
    step();
    br_taken = 1'b0;
    chk("ill.fault", {31'd0, fault}, 32'd1);
    chk("ill.valid", {31'd0, if_valid}, 32'd0);
    chk("ill.instr", if_instr, NOP);
    chk("ill.addr", imem_addr, 32'h78);
    chk("ill.rcnt", redirect_cnt, 32'd2);
    step();
    chk("ill.hold", {31'd0, fault}, 32'd1);
    chk("ill.fcnt", fetch_cnt, 32'd10);
    // Aligned but one past the end: still illegal, stays in FAULT
    br_taken  = 1'b1;
    br_target = 32'h1000;
    step();
    br_taken = 1'b0;
    chk("ill2.fault", {31'd0, fault}, 32'd1);
    chk("ill2.rcnt", redirect_cnt, 32'd2);
    // Legal redirect out of FAULT, fetch on following edge
    br_taken  = 1'b1;
    br_target = 32'h4;
    step();
    br_taken = 1'b0;
    chk("rec.fault", {31'd0, fault}, 32'd0);
    chk("rec.valid", {31'd0, if_valid}, 32'd0);
    chk("rec.rcnt", redirect_cnt, 32'd3);
    step();
    chk_slot("rec.tgt", 1'b1, 32'h4, 32'h1000_0001);
    chk("rec.fcnt", fetch_cnt, 32'd11);

    // Run off the end of memory
    br_taken  = 1'b1;
    br_target = 32'hFFC;
    step();
    br_taken = 1'b0;
    chk("end.rcnt", redirect_cnt, 32'd4);
    step();
    chk_slot("end.last", 1'b1, 32'hFFC, 32'h1000_03FF);
    chk("end.addr", imem_addr, 32'h1000);
    step();
    chk("end.fault", {31'd0, fault}, 32'd1);
    chk_slot("end.nofetch", 1'b0, 32'hFFC, NOP);
    chk("end.fcnt", fetch_cnt, 32'd12);
    step();
    chk("end.valid2", {31'd0, if_valid}, 32'd0);

    // Back to RUN, then async reset between edges during a stall
    br_taken  = 1'b1;
    br_target = 32'h8;
    step();
    br_taken = 1'b0;
    step();
    chk_slot("pre.rst", 1'b1, 32'h8, 32'h1000_0002);
    id_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_slot("arst", 1'b0, 32'h0, NOP);
    chk("arst.fault", {31'd0, fault}, 32'd0);
    chk("arst.addr", imem_addr, 32'h4);
    chk("arst.fcnt", fetch_cnt, 32'd0);
    chk("arst.rcnt", redirect_cnt, 32'd0);
    #2;
    rst_n     = 1'b1;
    id_ready  = 1'b1;
    // Redirect during BOOT must be ignored
    br_taken  = 1'b1;
    br_target = 32'h74;
    step();
    br_taken = 1'b0;
    chk("boot2.valid", {31'd0, if_valid}, 32'd0);
    chk("boot2.addr", imem_addr, 32'h4);
    chk("boot2.rcnt", redirect_cnt, 32'd0);
    step();
    chk_slot("boot2.first", 1'b1, 32'h4, 32'h1000_0001);
    chk("boot2.fcnt", fetch_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
